spi_master_engine: RTL

Serial engine of the AXI-to-SPI bridge. It sits directly downstream of the AXI-lite register front-end. It accepts one transfer command at a time (data, bit count, mode, clock divider) and drives the SPI pins (sclk, cs_n, mosi) while sampling miso. It returns the received word to the front-end with a one-cycle response pulse. Its pins are the DUT-side signals driven into the SPI slave agent.

---
 rtl/spi_master_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_engine.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_engine
// Purpose  : Single-command SPI master; shifts one word out on mosi and
//            returns the word sampled on miso with a one-cycle pulse.
// Revision : 1.0
// ============================================================================
module spi_master_engine #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_cpol,
    input  logic              cmd_cpha,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic              cmd_cs_hold,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rsp_data;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_bit;
    logic [LEN_W:0]    r_edge;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic              r_cpha;
    logic              r_hold;
    logic              r_sclk;
    logic              r_cs_n;
    logic              r_mosi;
    logic              w_accept;
    logic              w_expire;
    logic              w_last_edge;
    logic              w_leading;
    logic              w_timed;
    logic [LEN_W-1:0]  w_bit_m1;

    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    assign w_expire    = (r_cnt == r_div);
    assign w_last_edge = (r_edge == {r_len, 1'b1});
    assign w_leading   = ~r_edge[0];
    assign w_timed     = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);
    assign w_bit_m1    = r_bit - 1'b1;

    assign sclk     = r_sclk;
    assign cs_n     = r_cs_n;
    assign mosi     = r_mosi;
    assign rsp_data = r_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SETUP;
            S_SETUP: if (w_expire) w_next = S_SHIFT;
            S_SHIFT: if (w_expire && w_last_edge) w_next = S_HOLD;
            S_HOLD:  if (w_expire) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        rsp_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_rsp_data <= '0;
            r_len      <= '0;
            r_bit      <= '0;
            r_edge     <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_cpha     <= 1'b0;
            r_hold     <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            if (w_timed && !w_expire) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tx   <= cmd_data;
                        r_rx   <= '0;
                        r_len  <= cmd_len;
                        r_bit  <= cmd_len;
                        r_edge <= '0;
                        r_div  <= cmd_div;
                        r_cpha <= cmd_cpha;
                        r_hold <= cmd_cs_hold;
                        r_cs_n <= 1'b0;
                        // The sclk register doubles as the latched polarity; a held
                        // chip select keeps the polarity of the earlier transfer.
                        if (r_cs_n) begin
                            r_sclk <= cmd_cpol;
                        end
                        if (!cmd_cpha) begin
                            r_mosi <= cmd_data[cmd_len];
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_expire) begin
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + 1'b1;
                        if (w_leading ^ r_cpha) begin
                            r_rx <= {r_rx[DATA_W-2:0], miso};
                        end else if (r_cpha) begin
                            r_mosi <= r_tx[r_bit];
                            r_bit  <= w_bit_m1;
                        end else if (!w_last_edge) begin
                            r_mosi <= r_tx[w_bit_m1];
                            r_bit  <= w_bit_m1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_expire) begin
                        r_rsp_data <= r_rx;
                        if (!r_hold) begin
                            r_cs_n <= 1'b1;
                            r_mosi <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
